// File: rtl/issue_throttle_ctrl_if.sv
// Throttle/issue bus between the power monitor, the SM issue arbiter and
// the issue throttle controller. The controller connects through the
// slave modport; the driving side (monitor/arbiter model) uses master.
interface issue_throttle_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             throttle_req;
    logic             emerg_req;
    logic             issue_req;
    logic             issue_grant;
    logic [3:0]       level;
    logic             throttling;
    logic             stat_clr;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output throttle_req,
        output emerg_req,
        output issue_req,
        output stat_clr,
        input  issue_grant,
        input  level,
        input  throttling,
        input  stall_cnt
    );

    modport slave (
        input  throttle_req,
        input  emerg_req,
        input  issue_req,
        input  stat_clr,
        output issue_grant,
        output level,
        output throttling,
        output stall_cnt
    );
endinterface

// File: rtl/issue_throttle_ctrl.sv
// Issue throttle controller: turns a binary throttle request into a ramped
// duty cycle that blocks the first `level` slots of every 16-slot frame.
// Level ramps up/down at bounded rates with a hold dwell to limit di/dt.
module issue_throttle_ctrl #(
    parameter int MAX_LEVEL   = 12,
    parameter int RAMP_UP_CYC = 4,
    parameter int HOLD_CYC    = 64,
    parameter int RAMP_DN_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    issue_throttle_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN
    } state_t;

    localparam logic [3:0] MAX_LVL = 4'(MAX_LEVEL);
    localparam logic [7:0] UP_LAST = 8'(RAMP_UP_CYC - 1);
    localparam logic [7:0] HD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [7:0] DN_LAST = 8'(RAMP_DN_CYC - 1);

    state_t           state_q, state_d;
    logic [3:0]       level_q, level_d;
    logic [7:0]       timer_q, timer_d;
    logic [3:0]       slot_q;
    logic             throttling_q;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             allow;

    // Slot gating is combinational off registered slot/level.
    assign allow           = (slot_q >= level_q);
    assign bus.issue_grant = bus.issue_req & allow;
    assign bus.level       = level_q;
    assign bus.throttling  = throttling_q;
    assign bus.stall_cnt   = stall_q;

    // Next-state, level and timer; emergency overrides every state.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        timer_d = timer_q;
        if (bus.emerg_req) begin
            level_d = MAX_LVL;
            timer_d = '0;
            state_d = bus.throttle_req ? RAMP_UP : HOLD;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.throttle_req) begin
                        state_d = RAMP_UP;
                        level_d = 4'd1;
                        timer_d = '0;
                    end
                end
                RAMP_UP: begin
                    if (!bus.throttle_req) begin
                        state_d = HOLD;
                        timer_d = '0;
                    end else if (timer_q == UP_LAST) begin
                        timer_d = '0;
                        if (level_q < MAX_LVL) level_d = level_q + 4'd1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (bus.throttle_req) begin
                        state_d = RAMP_UP;
                        timer_d = '0;
                    end else if (timer_q == HD_LAST) begin
                        state_d = RAMP_DOWN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                RAMP_DOWN: begin
                    if (bus.throttle_req) begin
                        state_d = RAMP_UP;
                        timer_d = '0;
                    end else if (timer_q == DN_LAST) begin
                        timer_d = '0;
                        level_d = level_q - 4'd1;
                        if (level_q == 4'd1) state_d = IDLE;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        stall_d = stall_q;
        if (bus.stat_clr)
            stall_d = '0;
        else if (bus.issue_req && !allow && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    // State, level, slot and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            level_q      <= '0;
            timer_q      <= '0;
            slot_q       <= '0;
            throttling_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            slot_q       <= slot_q + 4'd1;
            throttling_q <= (level_d != 4'd0);
            stall_q      <= stall_d;
        end
    end
endmodule

// File: tb/tb_issue_throttle_ctrl.sv
// Scoreboard bench for issue_throttle_ctrl: a phase/elapsed-count reference
// model predicts every cycle's outputs into a queue; a negedge monitor pops
// and compares. A second instance with a 4-bit stall counter covers saturation.
module tb_issue_throttle_ctrl;
    localparam int MAXL = 12;
    localparam int RU   = 4;
    localparam int HC   = 64;
    localparam int RD   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_throttle_ctrl_if #(.CNT_W(16)) bus ();
    issue_throttle_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.throttle_req = bus.throttle_req;
    assign bus4.emerg_req    = bus.emerg_req;
    assign bus4.issue_req    = bus.issue_req;
    assign bus4.stat_clr     = bus.stat_clr;

    issue_throttle_ctrl #(.MAX_LEVEL(MAXL), .RAMP_UP_CYC(RU), .HOLD_CYC(HC),
                          .RAMP_DN_CYC(RD), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    issue_throttle_ctrl #(.MAX_LEVEL(MAXL), .RAMP_UP_CYC(RU), .HOLD_CYC(HC),
                          .RAMP_DN_CYC(RD), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        logic       grant;
        logic [3:0] level;
        logic       throttling;
        int         stall;
        int         stall4;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: phase plus edges elapsed since entering the phase.
    typedef enum {M_OFF, M_RISE, M_DWELL, M_FALL} phase_t;
    phase_t ph = M_OFF;
    int lvl = 0, n = 0, slot = 0, st = 0, st4 = 0;
    logic c_thr = 0, c_em = 0, c_req = 0, c_clr = 0, c_rst = 1;

    task automatic model_edge();
        bit blocked;
        if (c_rst) begin
            ph = M_OFF; lvl = 0; n = 0; slot = 0; st = 0; st4 = 0;
            return;
        end
        blocked = c_req && (slot < lvl);
        if (c_clr) begin
            st = 0; st4 = 0;
        end else if (blocked) begin
            if (st < 65535) st++;
            if (st4 < 15) st4++;
        end
        slot = (slot + 1) % 16;
        if (c_em) begin
            lvl = MAXL; n = 0;
            ph = c_thr ? M_RISE : M_DWELL;
        end else begin
            case (ph)
                M_OFF: if (c_thr) begin ph = M_RISE; lvl = 1; n = 0; end
                M_RISE: begin
                    if (!c_thr) begin ph = M_DWELL; n = 0; end
                    else begin
                        n++;
                        if (n % RU == 0 && lvl < MAXL) lvl++;
                    end
                end
                M_DWELL: begin
                    if (c_thr) begin ph = M_RISE; n = 0; end
                    else begin
                        n++;
                        if (n == HC) begin ph = M_FALL; n = 0; end
                    end
                end
                M_FALL: begin
                    if (c_thr) begin ph = M_RISE; n = 0; end
                    else begin
                        n++;
                        if (n % RD == 0) begin
                            lvl--;
                            if (lvl == 0) begin ph = M_OFF; n = 0; end
                        end
                    end
                end
                default: ph = M_OFF;
            endcase
        end
    endtask

    task automatic step(input logic thr, input logic em, input logic req,
                        input logic clr, input logic rs);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        c_thr = thr; c_em = em; c_req = req; c_clr = clr; c_rst = rs;
        bus.throttle_req = thr;
        bus.emerg_req    = em;
        bus.issue_req    = req;
        bus.stat_clr     = clr;
        rst              = rs;
        e.grant      = req && (slot >= lvl);
        e.level      = 4'(lvl);
        e.throttling = (lvl != 0);
        e.stall      = st;
        e.stall4     = st4;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("issue_grant", int'(bus.issue_grant), int'(e.grant));
            chk("level", int'(bus.level), int'(e.level));
            chk("throttling", int'(bus.throttling), int'(e.throttling));
            chk("stall_cnt", int'(bus.stall_cnt), e.stall);
            chk("stall_cnt4", int'(bus4.stall_cnt), e.stall4);
            chk("issue_grant4", int'(bus4.issue_grant), int'(e.grant));
        end
    end

    initial begin
        bus.throttle_req = 0;
        bus.emerg_req    = 0;
        bus.issue_req    = 0;
        bus.stat_clr     = 0;
        rst              = 1;

        // reset, then unthrottled issue
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        repeat (20) step(0, 0, 1, 0, 0);

        // ramp to max, hold there, then drop and ramp fully down
        repeat (150) step(1, 0, 1, 0, 0);
        repeat (270) step(0, 0, 1, 0, 0);

        // level 4 dwell: 32 requests, then clear together with a blocked request
        step(0, 0, 0, 1, 0);
        repeat (13) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (32) step(0, 0, 1, 0, 0);
        repeat (15) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        repeat (300) step(0, 0, 0, 0, 0);

        // emergency while ramping down at level 5
        repeat (50) step(1, 0, 0, 0, 0);
        repeat (180) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (300) step(0, 0, 1, 0, 0);

        // reassert during hold at level 7
        repeat (26) step(1, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        repeat (10) step(1, 0, 1, 0, 0);

        // reset mid ramp-up
        step(1, 0, 1, 0, 1);
        repeat (5) step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // randomized traffic
        begin
            logic thr = 0;
            for (int unsigned i = 0; i < 4000; i++) begin
                if ($urandom_range(39) == 0) thr = ~thr;
                step(thr, ($urandom_range(249) == 0), ($urandom_range(3) != 0),
                     ($urandom_range(149) == 0), ($urandom_range(1999) == 0));
            end
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
